// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes on both sides.
// S1 registers the operation; S2 holds the result and flags. The architectural
// carry register is updated at the S1->S2 transfer, so ADC/SBB chains need no
// forwarding: the op in S1 always sees the carry of the op just ahead of it.
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_z,
    output logic             out_c,
    output logic             out_n,
    output logic             out_v,
    output logic             carry_flag
);

    typedef enum logic [2:0] {
        OpAdd   = 3'b000,
        OpAdc   = 3'b001,
        OpSub   = 3'b010,
        OpSbb   = 3'b011,
        OpAnd   = 3'b100,
        OpOr    = 3'b101,
        OpXor   = 3'b110,
        OpPassB = 3'b111
    } op_e;

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             s1_cin_q,   s1_cin_d;

    // Stage 2 state
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_d_q,     s2_d_d;
    logic             s2_z_q,     s2_z_d;
    logic             s2_c_q,     s2_c_d;
    logic             s2_n_q,     s2_n_d;
    logic             s2_v_q,     s2_v_d;

    logic             carry_q,    carry_d;

    // Handshake and ALU datapath
    logic             s1_to_s2;
    logic             accept;
    logic             out_fire;
    logic [WIDTH-1:0] opb;
    logic             cin_sel;
    logic             arith;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    assign out_fire = s2_valid_q && out_ready;
    assign s1_to_s2 = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_to_s2;
    assign accept   = in_valid && in_ready;

    // Operand selection and WIDTH+1-bit sum; subtraction is A + ~B + carry-in
    always_comb begin
        opb     = s1_b_q;
        cin_sel = 1'b0;
        arith   = 1'b1;
        case (s1_op_q)
            OpAdd: cin_sel = s1_cin_q;
            OpAdc: cin_sel = carry_q;
            OpSub: begin
                opb     = ~s1_b_q;
                cin_sel = 1'b1;
            end
            OpSbb: begin
                opb     = ~s1_b_q;
                cin_sel = carry_q;
            end
            default: arith = 1'b0;
        endcase
        sum = {1'b0, s1_a_q} + {1'b0, opb} + {{WIDTH{1'b0}}, cin_sel};
    end

    // Result mux and C/V flags; logic ops and PASSB force C and V low
    always_comb begin
        case (s1_op_q)
            OpAnd:   res = s1_a_q & s1_b_q;
            OpOr:    res = s1_a_q | s1_b_q;
            OpXor:   res = s1_a_q ^ s1_b_q;
            OpPassB: res = s1_b_q;
            default: res = sum[WIDTH-1:0];
        endcase
        res_c = arith && sum[WIDTH];
        res_v = arith && (s1_a_q[WIDTH-1] == opb[WIDTH-1])
                      && (res[WIDTH-1] != s1_a_q[WIDTH-1]);
    end

    // Next-state for both stages and the carry register
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_cin_d   = s1_cin_q;
        s2_valid_d = s2_valid_q;
        s2_d_d     = s2_d_q;
        s2_z_d     = s2_z_q;
        s2_c_d     = s2_c_q;
        s2_n_d     = s2_n_q;
        s2_v_d     = s2_v_q;
        carry_d    = carry_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op_e'(in_op);
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_cin_d   = in_cin;
        end else if (s1_to_s2) begin
            s1_valid_d = 1'b0;
        end

        // S2 reloads on the same edge it drains, so no bubble under full flow
        if (s1_to_s2) begin
            s2_valid_d = 1'b1;
            s2_d_d     = res;
            s2_z_d     = (res == '0);
            s2_c_d     = res_c;
            s2_n_d     = res[WIDTH-1];
            s2_v_d     = res_v;
            carry_d    = res_c;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset that discards in-flight ops
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OpAdd;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_d_q     <= '0;
            s2_z_q     <= 1'b0;
            s2_c_q     <= 1'b0;
            s2_n_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_cin_q   <= s1_cin_d;
            s2_valid_q <= s2_valid_d;
            s2_d_q     <= s2_d_d;
            s2_z_q     <= s2_z_d;
            s2_c_q     <= s2_c_d;
            s2_n_q     <= s2_n_d;
            s2_v_q     <= s2_v_d;
            carry_q    <= carry_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_d      = s2_d_q;
    assign out_z      = s2_z_q;
    assign out_c      = s2_c_q;
    assign out_n      = s2_n_q;
    assign out_v      = s2_v_q;
    assign carry_flag = carry_q;

endmodule
